// File: rtl/turn_switch_ctrl.sv
// ----------------------------------------------------------------------------
// turn_switch_ctrl
//
// Purpose:
//   Turn-switch controller for a 2..4 player board game. It tracks which
//   player is active and ends the local player's turn in one of two ways:
//   draw DRAW_CNT cards and then pass (draw-and-next), or pass directly
//   (done-and-next). In both cases it broadcasts a STATE_TURN message that
//   names the next player. When the remote board sends STATE_TURN, the
//   active player is updated from the payload.
//
// Optional feature (macro TURN_TIMEOUT_EN):
//   A 32-bit turn timer runs while it is the local player's turn and the FSM
//   is idle. When it expires, the controller forces a draw-and-next if the
//   deck allows it, and a done-and-next otherwise. timeout_pending stays
//   high until the turn changes. With the macro undefined there is no timer
//   and timeout_pending is 0.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   interboard_rst       synchronous reset from the remote board (same as rst)
//   game_running         game is in a play state
//   done_and_next        pulse: end the turn without drawing
//   draw_and_next        pulse: draw DRAW_CNT cards, then end the turn
//   can_done, can_draw   legality of done / deck non-empty
//   my_card_cnt          local hand size
//   inter_ready          transmitter finished the previous message
//   interboard_en/_msg_type/_block_x   received message
//   draw_done            draw engine finished one card
//   draw_req             pulse: draw one card
//   active_player        ID of the player whose turn it is
//   my_turn              it is the local player's turn and the game is running
//   switch_turn          pulse: the turn changed
//   ctrl_en/_msg_type/_block_x   outgoing message
//   timeout_pending      a forced end of turn is in progress
// ----------------------------------------------------------------------------
`ifndef STATE_TURN
`define STATE_TURN 4'd5
`endif

module turn_switch_ctrl #(
   parameter int          PLAYER         = 0,
   parameter int          NUM_PLAYERS    = 2,
   parameter int          DRAW_CNT       = 1,
   parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       interboard_rst,
   input  logic       game_running,
   input  logic       done_and_next,
   input  logic       draw_and_next,
   input  logic       can_done,
   input  logic       can_draw,
   input  logic [6:0] my_card_cnt,
   input  logic       inter_ready,
   input  logic       interboard_en,
   input  logic [3:0] interboard_msg_type,
   input  logic [4:0] interboard_block_x,
   input  logic       draw_done,
   output logic       draw_req,
   output logic [1:0] active_player,
   output logic       my_turn,
   output logic       switch_turn,
   output logic       ctrl_en,
   output logic [3:0] ctrl_msg_type,
   output logic [4:0] ctrl_block_x,
   output logic       timeout_pending
);

   localparam logic [1:0] LP_PLAYER   = PLAYER[1:0];
   localparam logic [2:0] LP_NUM      = NUM_PLAYERS[2:0];
   localparam logic [1:0] LP_LAST     = 2'(NUM_PLAYERS - 1);
   localparam logic [1:0] LP_DRAW_CNT = DRAW_CNT[1:0];

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_DRAW_REQ  = 3'd1,
      S_DRAW_WAIT = 3'd2,
      S_SEND      = 3'd3,
      S_WAIT_TX   = 3'd4,
      S_FIN       = 3'd5
   } state_t;

   state_t     r_state;
   logic [1:0] r_active_player;
   logic [1:0] r_new_player;
   logic [1:0] r_draw_cnt;
   logic       r_draw_req;
   logic       r_ctrl_en;
   logic       r_switch_turn;
   logic [3:0] r_ctrl_msg_type;
   logic [4:0] r_ctrl_block_x;

   logic       w_rst;
   logic       w_my_turn;
   logic [1:0] w_next_player;
   logic [1:0] w_rx_player;
   logic       w_timeout_hit;
   logic       w_go_draw;
   logic       w_go_done;
   logic       w_go_remote;
   logic       w_draw_last;

   assign w_rst     = rst | interboard_rst;
   assign w_my_turn = (r_active_player == LP_PLAYER) && game_running;

   // Wrap after the last seated player (for three players, 2 goes to 0).
   assign w_next_player = (r_active_player == LP_LAST) ? 2'd0 : (r_active_player + 2'd1);

   // A remote ID that names a seat that does not exist falls back to player 0.
   assign w_rx_player = ({1'b0, interboard_block_x[1:0]} >= LP_NUM) ? 2'd0
                                                                    : interboard_block_x[1:0];

   // The timer pulse behaves like a draw_and_next, or like a done_and_next
   // that skips the legality checks when the deck is empty.
   assign w_go_draw   = w_my_turn && can_draw && (draw_and_next || w_timeout_hit);
   assign w_go_done   = w_my_turn && ((done_and_next && can_done && (my_card_cnt != 7'd0))
                                      || (w_timeout_hit && !can_draw));
   assign w_go_remote = interboard_en && (interboard_msg_type == `STATE_TURN) && !w_my_turn;
   assign w_draw_last = ((r_draw_cnt + 2'd1) == LP_DRAW_CNT);

`ifdef TURN_TIMEOUT_EN
   logic [31:0] r_timer;
   logic        r_timeout_pending;

   assign w_timeout_hit = (r_state == S_IDLE) && w_my_turn
                          && (r_timer == (TIMEOUT_CYCLES - 32'd1));

   // Turn timer: runs only while idle on our own turn and restarts otherwise.
   always_ff @(posedge clk) begin
      if (w_rst) begin
         r_timer <= 32'd0;
      end else if ((r_state == S_IDLE) && w_my_turn && !w_timeout_hit) begin
         r_timer <= r_timer + 32'd1;
      end else begin
         r_timer <= 32'd0;
      end
   end

   // Forced-turn flag: set on expiry and dropped as the turn changes.
   always_ff @(posedge clk) begin
      if (w_rst) begin
         r_timeout_pending <= 1'b0;
      end else if (w_timeout_hit) begin
         r_timeout_pending <= 1'b1;
      end else if ((r_state == S_WAIT_TX) && inter_ready) begin
         r_timeout_pending <= 1'b0;
      end else begin
         r_timeout_pending <= r_timeout_pending;
      end
   end

   assign timeout_pending = r_timeout_pending;
`else
   logic w_unused;

   // Upper payload bits and the timer length have no use in this build.
   assign w_unused        = ^{interboard_block_x[4:2], (TIMEOUT_CYCLES == 32'd0)};
   assign w_timeout_hit   = 1'b0;
   assign timeout_pending = 1'b0;
`endif

   // Turn-switch FSM. The pulse outputs are registered on the transition
   // into the state that owns them, so each pulse lines up with its state.
   always_ff @(posedge clk) begin
      if (w_rst) begin
         r_state         <= S_IDLE;
         r_active_player <= 2'd0;
         r_new_player    <= 2'd0;
         r_draw_cnt      <= 2'd0;
         r_draw_req      <= 1'b0;
         r_ctrl_en       <= 1'b0;
         r_switch_turn   <= 1'b0;
         r_ctrl_msg_type <= 4'd0;
         r_ctrl_block_x  <= 5'd0;
      end else begin
         r_draw_req    <= 1'b0;
         r_ctrl_en     <= 1'b0;
         r_switch_turn <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_go_draw) begin
                  r_state    <= S_DRAW_REQ;
                  r_draw_cnt <= 2'd0;
                  r_draw_req <= 1'b1;
               end else if (w_go_done) begin
                  r_state         <= S_SEND;
                  r_ctrl_en       <= 1'b1;
                  r_ctrl_msg_type <= `STATE_TURN;
                  r_ctrl_block_x  <= {3'b000, w_next_player};
                  r_new_player    <= w_next_player;
               end else if (w_go_remote) begin
                  r_state         <= S_FIN;
                  r_switch_turn   <= 1'b1;
                  r_active_player <= w_rx_player;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_DRAW_REQ: begin
               r_state <= S_DRAW_WAIT;
            end
            S_DRAW_WAIT: begin
               if (draw_done) begin
                  r_draw_cnt <= r_draw_cnt + 2'd1;
                  // An empty deck ends the draw early; the turn still passes.
                  if (w_draw_last || !can_draw) begin
                     r_state         <= S_SEND;
                     r_ctrl_en       <= 1'b1;
                     r_ctrl_msg_type <= `STATE_TURN;
                     r_ctrl_block_x  <= {3'b000, w_next_player};
                     r_new_player    <= w_next_player;
                  end else begin
                     r_state    <= S_DRAW_REQ;
                     r_draw_req <= 1'b1;
                  end
               end else begin
                  r_state <= S_DRAW_WAIT;
               end
            end
            S_SEND: begin
               r_state <= S_WAIT_TX;
            end
            S_WAIT_TX: begin
               if (inter_ready) begin
                  r_state         <= S_FIN;
                  r_switch_turn   <= 1'b1;
                  r_active_player <= r_new_player;
               end else begin
                  r_state <= S_WAIT_TX;
               end
            end
            S_FIN: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign draw_req      = r_draw_req;
   assign active_player = r_active_player;
   assign my_turn       = w_my_turn;
   assign switch_turn   = r_switch_turn;
   assign ctrl_en       = r_ctrl_en;
   assign ctrl_msg_type = r_ctrl_msg_type;
   assign ctrl_block_x  = r_ctrl_block_x;

endmodule

// File: tb/tb_turn_switch_ctrl.sv
// ----------------------------------------------------------------------------
// tb_turn_switch_ctrl
//
// Directed bench for turn_switch_ctrl with PLAYER=2, NUM_PLAYERS=3 and
// DRAW_CNT=3. Every pulse the DUT emits (draw_req, ctrl_en, switch_turn) is
// taken off an expected-event queue that the stimulus fills beforehand. The
// stimulus process also checks levels (reset state, active_player, my_turn)
// and latencies directly.
// ----------------------------------------------------------------------------
`ifndef STATE_TURN
`define STATE_TURN 4'd5
`endif

module tb_turn_switch_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       interboard_rst;
   logic       game_running;
   logic       done_and_next;
   logic       draw_and_next;
   logic       can_done;
   logic       can_draw;
   logic [6:0] my_card_cnt;
   logic       inter_ready;
   logic       interboard_en;
   logic [3:0] interboard_msg_type;
   logic [4:0] interboard_block_x;
   logic       draw_done;
   logic       draw_req;
   logic [1:0] active_player;
   logic       my_turn;
   logic       switch_turn;
   logic       ctrl_en;
   logic [3:0] ctrl_msg_type;
   logic [4:0] ctrl_block_x;
   logic       timeout_pending;

   always #5 clk = ~clk;

   turn_switch_ctrl #(
      .PLAYER(2), .NUM_PLAYERS(3), .DRAW_CNT(3)
   ) dut (
      .clk(clk), .rst(rst), .interboard_rst(interboard_rst),
      .game_running(game_running), .done_and_next(done_and_next),
      .draw_and_next(draw_and_next), .can_done(can_done), .can_draw(can_draw),
      .my_card_cnt(my_card_cnt), .inter_ready(inter_ready),
      .interboard_en(interboard_en), .interboard_msg_type(interboard_msg_type),
      .interboard_block_x(interboard_block_x), .draw_done(draw_done),
      .draw_req(draw_req), .active_player(active_player), .my_turn(my_turn),
      .switch_turn(switch_turn), .ctrl_en(ctrl_en), .ctrl_msg_type(ctrl_msg_type),
      .ctrl_block_x(ctrl_block_x), .timeout_pending(timeout_pending)
   );

   typedef struct packed {
      logic [2:0] kind;
      logic [3:0] msg;
      logic [4:0] bx;
      logic [1:0] ap;
   } exp_t;

   localparam logic [2:0] K_DRAW = 3'b001;
   localparam logic [2:0] K_CTRL = 3'b010;
   localparam logic [2:0] K_SW   = 3'b100;

   localparam int P_DONE   = 0;
   localparam int P_DRAW   = 1;
   localparam int P_READY  = 2;
   localparam int P_REMOTE = 3;
   localparam int P_DDONE  = 4;

   exp_t       exp_q[$];
   int         n_checks = 0;
   int         n_fail   = 0;
   logic [2:0] mon_k;
   exp_t       mon_e;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   task automatic push(input logic [2:0] kind, input logic [4:0] bx, input logic [1:0] ap);
      exp_t e;
      e.kind = kind;
      e.msg  = `STATE_TURN;
      e.bx   = bx;
      e.ap   = ap;
      exp_q.push_back(e);
   endtask

   // Monitor: every pulse seen on the falling edge must match the queue head.
   always @(negedge clk) begin
      mon_k = {switch_turn, ctrl_en, draw_req};
      if (mon_k != 3'b000) begin
         if (exp_q.size() == 0) begin
            check("unexpected_pulse", {29'd0, mon_k}, 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check("pulse_kind", {29'd0, mon_k}, {29'd0, mon_e.kind});
            check("pulse_timeout_pending", {31'd0, timeout_pending}, 32'd0);
            if (mon_e.kind == K_CTRL) begin
               check("ctrl_msg_type", {28'd0, ctrl_msg_type}, {28'd0, mon_e.msg});
               check("ctrl_block_x", {27'd0, ctrl_block_x}, {27'd0, mon_e.bx});
            end
            if (mon_e.kind == K_SW) begin
               check("switch_active_player", {30'd0, active_player}, {30'd0, mon_e.ap});
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int which, input logic v);
      case (which)
         P_DONE:   done_and_next = v;
         P_DRAW:   draw_and_next = v;
         P_READY:  inter_ready   = v;
         P_REMOTE: interboard_en = v;
         default:  draw_done     = v;
      endcase
   endtask

   task automatic pulse(input int which);
      tick();
      drive(which, 1'b1);
      tick();
      drive(which, 1'b0);
   endtask

   task automatic remote(input logic [4:0] bx);
      interboard_msg_type = `STATE_TURN;
      interboard_block_x  = bx;
      pulse(P_REMOTE);
   endtask

   // Bounded wait for draw_req (sel=0) or ctrl_en (sel=1).
   task automatic wait_for(input int sel, input string name);
      for (int i = 0; i < 10; i++) begin
         if ((sel == 0) ? draw_req : ctrl_en) return;
         tick();
      end
      n_checks++;
      n_fail++;
      $display("FAIL %s: pulse did not appear within 10 cycles", name);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; interboard_rst = 1'b0; game_running = 1'b0;
      done_and_next = 1'b0; draw_and_next = 1'b0; can_done = 1'b0; can_draw = 1'b0;
      my_card_cnt = 7'd0; inter_ready = 1'b0; interboard_en = 1'b0;
      interboard_msg_type = 4'd0; interboard_block_x = 5'd0; draw_done = 1'b0;
      repeat (3) tick();
      check("rst_active_player", {30'd0, active_player}, 32'd0);
      check("rst_pulses", {29'd0, switch_turn, ctrl_en, draw_req}, 32'd0);
      check("rst_msg", {23'd0, ctrl_msg_type, ctrl_block_x}, 32'd0);
      check("rst_timeout_pending", {31'd0, timeout_pending}, 32'd0);
      rst = 1'b0;
      game_running = 1'b1; can_done = 1'b1; can_draw = 1'b1; my_card_cnt = 7'd5;
      tick();
      check("not_my_turn", {31'd0, my_turn}, 32'd0);

      // done_and_next while it is player 0's turn: ignored.
      pulse(P_DONE);
      repeat (3) tick();
      check("ignored_done_ap", {30'd0, active_player}, 32'd0);
      check("ignored_done_msg", {28'd0, ctrl_msg_type}, 32'd0);

      // Remote STATE_TURN: switch_turn one cycle after interboard_en.
      push(K_SW, 5'd0, 2'd1);
      remote(5'd1);
      check("remote_latency", {31'd0, switch_turn}, 32'd1);
      check("remote_ap1", {30'd0, active_player}, 32'd1);
      push(K_SW, 5'd0, 2'd2);
      remote(5'd2);
      tick();
      check("my_turn_at_2", {31'd0, my_turn}, 32'd1);

      // done_and_next with an empty hand: ignored.
      my_card_cnt = 7'd0;
      pulse(P_DONE);
      repeat (3) tick();
      check("empty_hand_ap", {30'd0, active_player}, 32'd2);
      check("empty_hand_msg", {28'd0, ctrl_msg_type}, 32'd0);
      my_card_cnt = 7'd5;

      // Done path from player 2: next player wraps to 0.
      push(K_CTRL, 5'd0, 2'd0);
      push(K_SW, 5'd0, 2'd0);
      pulse(P_DONE);
      check("done_latency", {31'd0, ctrl_en}, 32'd1);
      tick();
      check("wait_tx_en_low", {31'd0, ctrl_en}, 32'd0);
      check("wait_tx_msg_held", {28'd0, ctrl_msg_type}, {28'd0, `STATE_TURN});
      tick();
      pulse(P_READY);
      check("ready_latency", {31'd0, switch_turn}, 32'd1);
      check("done_ap0", {30'd0, active_player}, 32'd0);

      // Remote ID 3 does not exist with three players: clamped to 0.
      push(K_SW, 5'd0, 2'd1);
      remote(5'd1);
      push(K_SW, 5'd0, 2'd0);
      remote(5'd3);
      check("clamp_ap", {30'd0, active_player}, 32'd0);

      // Draw three cards, then pass the turn.
      push(K_SW, 5'd0, 2'd2);
      remote(5'd2);
      push(K_DRAW, 5'd0, 2'd0);
      push(K_DRAW, 5'd0, 2'd0);
      push(K_DRAW, 5'd0, 2'd0);
      push(K_CTRL, 5'd0, 2'd0);
      push(K_SW, 5'd0, 2'd0);
      pulse(P_DRAW);
      for (int i = 0; i < 3; i++) begin
         wait_for(0, "draw_req_wait");
         tick();
         pulse(P_DDONE);
      end
      wait_for(1, "draw_ctrl_wait");
      pulse(P_READY);
      check("draw3_ap", {30'd0, active_player}, 32'd0);

      // Deck empties after the first card: a partial draw still passes.
      push(K_SW, 5'd0, 2'd2);
      remote(5'd2);
      push(K_DRAW, 5'd0, 2'd0);
      push(K_CTRL, 5'd0, 2'd0);
      push(K_SW, 5'd0, 2'd0);
      pulse(P_DRAW);
      wait_for(0, "partial_draw_wait");
      tick();
      can_draw = 1'b0;
      pulse(P_DDONE);
      wait_for(1, "partial_ctrl_wait");
      pulse(P_READY);
      can_draw = 1'b1;
      check("partial_ap", {30'd0, active_player}, 32'd0);

      // Remote STATE_TURN while waiting for the transmitter: ignored.
      push(K_SW, 5'd0, 2'd2);
      remote(5'd2);
      push(K_CTRL, 5'd0, 2'd0);
      push(K_SW, 5'd0, 2'd0);
      pulse(P_DONE);
      tick();
      remote(5'd1);
      tick();
      check("busy_remote_ap", {30'd0, active_player}, 32'd2);
      pulse(P_READY);
      check("busy_final_ap", {30'd0, active_player}, 32'd0);

      // draw_and_next when it is not our turn: ignored.
      pulse(P_DRAW);
      repeat (3) tick();
      check("ignored_draw_ap", {30'd0, active_player}, 32'd0);

      // Reset while waiting for draw_done; a late draw_done does nothing.
      push(K_SW, 5'd0, 2'd2);
      remote(5'd2);
      push(K_DRAW, 5'd0, 2'd0);
      pulse(P_DRAW);
      wait_for(0, "reset_draw_wait");
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_rst_ap", {30'd0, active_player}, 32'd0);
      check("mid_rst_msg", {28'd0, ctrl_msg_type}, 32'd0);
      pulse(P_DDONE);
      repeat (4) tick();
      check("post_rst_msg", {28'd0, ctrl_msg_type}, 32'd0);
      check("post_rst_ap", {30'd0, active_player}, 32'd0);

      check("queue_empty", exp_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
